// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter that serialises requester commands onto a single APB master,
// watches the bus for completion or timeout and returns the response to the owner.
module apb_cmd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      preset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_transfer,
  output logic                      m_read,
  output logic                      m_write,
  output logic [ADDR_W-1:0]         m_read_paddr,
  output logic [ADDR_W-1:0]         m_write_paddr,
  output logic [DATA_W-1:0]         m_write_data,
  input  logic                      apb_psel,
  input  logic                      apb_penable,
  input  logic                      apb_pready,
  input  logic                      apb_pslverr,
  input  logic [DATA_W-1:0]         apb_prdata,
  output logic                      busy
);

  localparam int GW    = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     last_grant, grant, win;
  logic              win_found;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] cap_rdata;
  logic              cap_err;
  logic              complete, timeout_hit, active;

  assign complete    = apb_psel & apb_penable & apb_pready;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign active      = (state == S_ISSUE) || (state == S_WAIT);

  // Scan upward from the requester after the last one served, wrapping around.
  always_comb begin
    int idx;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win       = GW'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    m_transfer = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found && !preset) begin
          req_ready[win] = 1'b1;
          state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_transfer = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        // Dropping transfer in the finishing cycle keeps the master from re-entering setup.
        m_transfer = !(complete || timeout_hit);
        if (complete || timeout_hit)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid[grant] = 1'b1;
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign m_read        = active & ~lat_write;
  assign m_write       = active & lat_write;
  assign m_read_paddr  = active ? lat_addr : '0;
  assign m_write_paddr = active ? lat_addr : '0;
  assign m_write_data  = (active && lat_write) ? lat_wdata : '0;
  assign rsp_rdata     = (state == S_RESP) ? cap_rdata : '0;
  assign rsp_err       = (state == S_RESP) & cap_err;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state      <= S_IDLE;
      last_grant <= GW'(N_REQ - 1);
      grant      <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      cap_rdata  <= '0;
      cap_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant     <= win;
            lat_write <= req_write[win];
            lat_addr  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[int'(win)*DATA_W +: DATA_W];
            cnt       <= '0;
          end
        end
        S_ISSUE: cnt <= cnt + CNT_W'(1);
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (complete) begin
            cap_rdata <= lat_write ? '0 : apb_prdata;
            cap_err   <= apb_pslverr;
          end else if (timeout_hit) begin
            cap_rdata <= '0;
            cap_err   <= 1'b1;
          end
        end
        S_RESP: last_grant <= grant;
        default: ;
      endcase
    end
  end

endmodule
